// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage LoongArch pipeline.
//
// Takes the decode bundle and does four things with it:
//   - computes the ALU result
//   - runs MUL/MULH/MULHU on a multi-cycle multiplier under a small FSM
//   - issues the data-SRAM request for ld.w/st.w
//   - forwards non-load results to decode, and registers the bundle for MEM
// Decode holds the bundle stable while EX_allowin is low, so this stage keeps
// no copy of it apart from the multiplier operand latches.
//
// Ports:
//   clk                  clock
//   rst                  synchronous reset, active-low
//   ID_to_EX_zip[184:0]  {valid, pc, inst, src1, src2, alu_op[11:0], is_load,
//                         mem_we, res_from_mem, gr_we, rkd_value, dest[4:0],
//                         mul, mulh, mulhu}
//   MEM_allowin          memory stage can accept
//   EX_allowin           execute stage can accept
//   front_from_EX_*      forwarding valid / register / value
//   data_sram_*          data SRAM en / byte we / addr / wdata
//   EX_to_MEM_reg[103:0] {valid, pc, inst, result, res_from_mem, gr_we, dest}
//
// Multiplier FSM:
//   state  | meaning
//   S_IDLE | no multiply in flight; a valid mul* latches operands here
//   S_BUSY | counting down; product registered when the counter hits 0
//   S_DONE | product held, stage ready; leaves when MEM accepts

module ex_stage #(
  parameter int MUL_LAT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [184:0] ID_to_EX_zip,
  input  logic         MEM_allowin,
  output logic         EX_allowin,
  output logic         front_from_EX_valid,
  output logic [4:0]   front_from_EX_addr,
  output logic [31:0]  front_from_EX_data,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_we,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata,
  output logic [103:0] EX_to_MEM_reg
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [2:0] CNT_INIT = 3'(MUL_LAT - 2);

  logic        w_valid;
  logic [31:0] w_pc;
  logic [31:0] w_inst;
  logic [31:0] w_src1;
  logic [31:0] w_src2;
  logic [11:0] w_alu_op;
  logic        w_is_load;
  logic        w_mem_we;
  logic        w_res_from_mem;
  logic        w_gr_we;
  logic [31:0] w_rkd_value;
  logic [4:0]  w_dest;
  logic        w_mul;
  logic        w_mulh;
  logic        w_mulhu;

  assign {w_valid, w_pc, w_inst, w_src1, w_src2, w_alu_op, w_is_load, w_mem_we,
          w_res_from_mem, w_gr_we, w_rkd_value, w_dest, w_mul, w_mulh,
          w_mulhu} = ID_to_EX_zip;

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [32:0] r_op_a;
  logic [32:0] r_op_b;
  logic [63:0] r_prod;

  logic        w_is_mul;
  logic        w_readygo;
  logic        w_sext;
  logic [63:0] w_prod;
  logic [31:0] w_mul_result;
  logic [31:0] w_add;
  logic [31:0] w_sub;
  logic        w_slt;
  logic        w_sltu;
  logic [31:0] w_sll;
  logic [31:0] w_srl;
  logic [31:0] w_sra;
  logic [31:0] w_alu_result;
  logic [31:0] w_result;

  assign w_is_mul  = w_mul | w_mulh | w_mulhu;
  assign w_readygo = ~w_is_mul | (r_state == S_DONE);
  assign EX_allowin = ~w_valid | (w_readygo & MEM_allowin);

  // ALU
  assign w_add  = w_src1 + w_src2;
  assign w_sub  = w_src1 - w_src2;
  assign w_slt  = $signed(w_src1) < $signed(w_src2);
  assign w_sltu = w_src1 < w_src2;
  assign w_sll  = w_src1 << w_src2[4:0];
  assign w_srl  = w_src1 >> w_src2[4:0];
  // kept as its own signed expression so the shift stays arithmetic
  assign w_sra  = $signed(w_src1) >>> w_src2[4:0];

  assign w_alu_result = ({32{w_alu_op[0]}}  & w_add)
                      | ({32{w_alu_op[1]}}  & w_sub)
                      | ({32{w_alu_op[2]}}  & {31'd0, w_slt})
                      | ({32{w_alu_op[3]}}  & {31'd0, w_sltu})
                      | ({32{w_alu_op[4]}}  & (w_src1 & w_src2))
                      | ({32{w_alu_op[5]}}  & ~(w_src1 | w_src2))
                      | ({32{w_alu_op[6]}}  & (w_src1 | w_src2))
                      | ({32{w_alu_op[7]}}  & (w_src1 ^ w_src2))
                      | ({32{w_alu_op[8]}}  & w_sll)
                      | ({32{w_alu_op[9]}}  & w_srl)
                      | ({32{w_alu_op[10]}} & w_sra)
                      | ({32{w_alu_op[11]}} & w_src2);

  // Multiplier. Operands are 33-bit so one signed multiply covers both
  // signed and unsigned forms; only the low 64 product bits are ever selected.
  assign w_sext = ~w_mulhu;
  assign w_prod = {{31{r_op_a[32]}}, r_op_a} * {{31{r_op_b[32]}}, r_op_b};
  assign w_mul_result = w_mul ? r_prod[31:0] : r_prod[63:32];

  assign w_result = w_is_mul ? w_mul_result : w_alu_result;

  // Memory request
  assign data_sram_en    = w_valid & (w_is_load | w_mem_we) & MEM_allowin;
  assign data_sram_we    = {4{w_mem_we & w_valid & MEM_allowin}};
  assign data_sram_addr  = w_alu_result;
  assign data_sram_wdata = w_rkd_value;

  // Forwarding; readygo keeps an unfinished multiply from being forwarded
  assign front_from_EX_valid = w_valid & w_gr_we & ~w_res_from_mem & w_readygo
                               & (w_dest != 5'd0);
  assign front_from_EX_addr  = w_dest;
  assign front_from_EX_data  = w_result;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_prod        <= '0;
      EX_to_MEM_reg <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_valid && w_is_mul) begin
            r_op_a  <= {w_sext & w_src1[31], w_src1};
            r_op_b  <= {w_sext & w_src2[31], w_src2};
            r_cnt   <= CNT_INIT;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt == 3'd0) begin
            r_prod  <= w_prod;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_DONE: begin
          if (MEM_allowin) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // a stalled multiply hands MEM a zero bundle rather than a duplicate
      if (MEM_allowin) begin
        if (w_readygo) begin
          EX_to_MEM_reg <= {w_valid, w_pc, w_inst, w_result, w_res_from_mem,
                            w_gr_we, w_dest};
        end else begin
          EX_to_MEM_reg <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

  logic         clk;
  logic         rst;
  logic [184:0] zip;
  logic         MEM_allowin;
  logic         EX_allowin;
  logic         fwd_valid;
  logic [4:0]   fwd_addr;
  logic [31:0]  fwd_data;
  logic         sram_en;
  logic [3:0]   sram_we;
  logic [31:0]  sram_addr;
  logic [31:0]  sram_wdata;
  logic [103:0] ex_to_mem;

  int n_checks = 0;
  int n_fail   = 0;
  logic [103:0] sb_q[$];
  logic [31:0]  pc_ctr = 32'h1c000000;
  logic         mon_ld;

  ex_stage #(.MUL_LAT(3)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .ID_to_EX_zip        (zip),
    .MEM_allowin         (MEM_allowin),
    .EX_allowin          (EX_allowin),
    .front_from_EX_valid (fwd_valid),
    .front_from_EX_addr  (fwd_addr),
    .front_from_EX_data  (fwd_data),
    .data_sram_en        (sram_en),
    .data_sram_we        (sram_we),
    .data_sram_addr      (sram_addr),
    .data_sram_wdata     (sram_wdata),
    .EX_to_MEM_reg       (ex_to_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got,
                          input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ctl = {is_load, mem_we, res_from_mem, gr_we}; mk3 = {mul, mulh, mulhu}
  function automatic logic [184:0] mk(input logic [31:0] s1, input logic [31:0] s2,
                                      input logic [11:0] op, input logic [3:0] ctl,
                                      input logic [31:0] rkd, input logic [4:0] dst,
                                      input logic [2:0] mk3);
    logic [31:0] pc;
    pc = pc_ctr;
    pc_ctr = pc_ctr + 32'd4;
    return {1'b1, pc, pc ^ 32'h02800000, s1, s2, op, ctl, rkd, dst, mk3};
  endfunction

  function automatic logic [31:0] golden(input logic [184:0] b);
    logic [31:0] a;
    logic [31:0] c;
    logic signed [63:0] ps;
    logic [63:0] pu;
    a  = b[119:88];
    c  = b[87:56];
    ps = $signed({{32{a[31]}}, a}) * $signed({{32{c[31]}}, c});
    pu = {32'd0, a} * {32'd0, c};
    if (b[2]) return ps[31:0];
    if (b[1]) return ps[63:32];
    if (b[0]) return pu[63:32];
    case (b[55:44])
      12'h001: return a + c;
      12'h002: return a - c;
      12'h004: return ($signed(a) < $signed(c)) ? 32'd1 : 32'd0;
      12'h008: return (a < c) ? 32'd1 : 32'd0;
      12'h010: return a & c;
      12'h020: return ~(a | c);
      12'h040: return a | c;
      12'h080: return a ^ c;
      12'h100: return a << c[4:0];
      12'h200: return a >> c[4:0];
      12'h400: return 32'($signed(a) >>> c[4:0]);
      12'h800: return c;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [103:0] exp_mem(input logic [184:0] b);
    return {b[184], b[183:120], golden(b), b[41], b[40], b[7:3]};
  endfunction

  // Drive a bundle at a negedge and hold it until EX accepts it; the expected
  // MEM bundle is queued just before the accepting edge.
  task automatic issue(input logic [184:0] b, output int waited,
                       output logic [103:0] bub);
    @(negedge clk);
    zip = b;
    MEM_allowin = 1'b1;
    waited = 0;
    bub = '1;
    #1;
    while (!EX_allowin && waited < 40) begin
      @(negedge clk);
      #1;
      waited++;
      if (waited == 1) bub = ex_to_mem;
    end
    check_eq("accept_timeout", 128'(EX_allowin), 128'(1'b1));
    if (EX_allowin) sb_q.push_back(exp_mem(b));
  endtask

  always @(posedge clk) begin
    mon_ld = MEM_allowin & rst;
    #1;
    if (mon_ld && ex_to_mem[103]) begin
      if (sb_q.size() == 0) check_eq("sb_underflow", 128'(ex_to_mem), 128'(0));
      else check_eq("sb_mem", 128'(ex_to_mem), 128'(sb_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  logic [31:0] t_a  [12] = '{32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0F0F0,
                             32'hF0F00000, 32'h0000FF00, 32'hAAAA5555, 32'd1,
                             32'h80000000, 32'h80000000, 32'h12345678, 32'h9};
  logic [31:0] t_b  [12] = '{32'd7, 32'd1, 32'd1, 32'h0FF00FF0, 32'h0000000F,
                             32'h00FF0000, 32'hFFFF0000, 32'h3F, 32'd4, 32'd4,
                             32'h12345000, 32'h9};
  logic [11:0] t_op [12] = '{12'h002, 12'h004, 12'h008, 12'h010, 12'h020, 12'h040,
                             12'h080, 12'h100, 12'h200, 12'h400, 12'h800, 12'h000};
  logic [31:0] t_mr [3]  = '{32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFA};
  logic [2:0]  t_mk [3]  = '{3'b010, 3'b001, 3'b100};

  initial begin
    int w;
    logic [103:0] bub;
    logic [103:0] hold;
    logic [184:0] b;

    rst = 1'b0;
    zip = '0;
    MEM_allowin = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("reset_mem", 128'(ex_to_mem), 128'(0));
    check_eq("reset_allowin", 128'(EX_allowin), 128'(1'b1));
    check_eq("reset_fwd_v", 128'(fwd_valid), 128'(1'b0));
    check_eq("reset_en", 128'(sram_en), 128'(1'b0));
    rst = 1'b1;

    // add with signed overflow wrap
    issue(mk(32'h7FFFFFFF, 32'd1, 12'h001, 4'b0001, 32'd0, 5'd5, 3'b000), w, bub);
    check_eq("add_fwd_v", 128'(fwd_valid), 128'(1'b1));
    check_eq("add_fwd_addr", 128'(fwd_addr), 128'(5'd5));
    check_eq("add_fwd_data", 128'(fwd_data), 128'(32'h80000000));
    check_eq("add_en", 128'(sram_en), 128'(1'b0));

    for (int i = 0; i < 12; i++) begin
      b = mk(t_a[i], t_b[i], t_op[i], 4'b0001, 32'd0, 5'(i + 8), 3'b000);
      issue(b, w, bub);
      check_eq("alu_fwd_data", 128'(fwd_data), 128'(golden(b)));
    end

    for (int i = 0; i < 3; i++) begin
      issue(mk(32'hFFFFFFFE, 32'd3, 12'h000, 4'b0001, 32'd0, 5'd6, t_mk[i]), w, bub);
      check_eq("mul_latency", 128'(w), 128'(3));
      check_eq("mul_bubble", 128'(bub), 128'(0));
      check_eq("mul_fwd_v", 128'(fwd_valid), 128'(1'b1));
      check_eq("mul_fwd_data", 128'(fwd_data), 128'(t_mr[i]));
    end

    // st.w first blocked by MEM, then accepted
    b = mk(32'h1000, 32'd8, 12'h001, 4'b0100, 32'hDEADBEEF, 5'd0, 3'b000);
    @(negedge clk);
    zip = b;
    MEM_allowin = 1'b0;
    hold = ex_to_mem;
    #1;
    check_eq("st_blk_en", 128'(sram_en), 128'(1'b0));
    check_eq("st_blk_we", 128'(sram_we), 128'(4'h0));
    check_eq("st_blk_allow", 128'(EX_allowin), 128'(1'b0));
    @(negedge clk);
    #1;
    check_eq("st_blk_hold", 128'(ex_to_mem), 128'(hold));
    issue(b, w, bub);
    check_eq("st_en", 128'(sram_en), 128'(1'b1));
    check_eq("st_we", 128'(sram_we), 128'(4'hF));
    check_eq("st_addr", 128'(sram_addr), 128'(32'h1008));
    check_eq("st_wdata", 128'(sram_wdata), 128'(32'hDEADBEEF));
    check_eq("st_fwd_v", 128'(fwd_valid), 128'(1'b0));

    issue(mk(32'h2000, 32'd4, 12'h001, 4'b1011, 32'd0, 5'd4, 3'b000), w, bub);
    check_eq("ld_fwd_v", 128'(fwd_valid), 128'(1'b0));
    check_eq("ld_en", 128'(sram_en), 128'(1'b1));
    check_eq("ld_we", 128'(sram_we), 128'(4'h0));
    check_eq("ld_addr", 128'(sram_addr), 128'(32'h2004));
    @(negedge clk);
    zip = '0;
    #1;
    check_eq("ld_rfm", 128'(ex_to_mem[6]), 128'(1'b1));

    // mul held in DONE while MEM stalls for 5 cycles
    b = mk(32'd6, 32'd7, 12'h000, 4'b0001, 32'd0, 5'd9, 3'b100);
    @(negedge clk);
    zip = b;
    MEM_allowin = 1'b1;
    #1;
    check_eq("hold_allow_t0", 128'(EX_allowin), 128'(1'b0));
    @(negedge clk);
    @(negedge clk);
    MEM_allowin = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      check_eq("done_allow", 128'(EX_allowin), 128'(1'b0));
      check_eq("done_fwd_v", 128'(fwd_valid), 128'(1'b1));
      check_eq("done_fwd_data", 128'(fwd_data), 128'(32'd42));
      check_eq("done_mem_bubble", 128'(ex_to_mem), 128'(0));
    end
    @(negedge clk);
    MEM_allowin = 1'b1;
    sb_q.push_back(exp_mem(b));
    #1;
    check_eq("done_allow_rel", 128'(EX_allowin), 128'(1'b1));
    issue(mk(32'd3, 32'd4, 12'h001, 4'b0001, 32'd0, 5'd7, 3'b000), w, bub);
    check_eq("next_wait", 128'(w), 128'(0));
    check_eq("next_fwd_v", 128'(fwd_valid), 128'(1'b1));
    check_eq("next_fwd_addr", 128'(fwd_addr), 128'(5'd7));
    check_eq("next_fwd_data", 128'(fwd_data), 128'(32'd7));

    // reset clears a valid MEM bundle
    @(negedge clk);
    zip = '0;
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_eq("rst_mem_clear", 128'(ex_to_mem), 128'(0));
    rst = 1'b1;

    // reset during BUSY, then a fresh multiply
    @(negedge clk);
    zip = mk(32'd5, 32'd5, 12'h000, 4'b0001, 32'd0, 5'd3, 3'b100);
    MEM_allowin = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    zip = '0;
    @(negedge clk);
    #1;
    check_eq("rst_busy_mem", 128'(ex_to_mem), 128'(0));
    check_eq("rst_busy_allow", 128'(EX_allowin), 128'(1'b1));
    rst = 1'b1;
    issue(mk(32'd9, 32'd9, 12'h000, 4'b0001, 32'd0, 5'd3, 3'b100), w, bub);
    check_eq("post_rst_latency", 128'(w), 128'(3));
    check_eq("post_rst_data", 128'(fwd_data), 128'(32'd81));

    issue(mk(32'd1, 32'd1, 12'h001, 4'b0001, 32'd0, 5'd0, 3'b000), w, bub);
    check_eq("dest0_fwd_v", 128'(fwd_valid), 128'(1'b0));

    @(negedge clk);
    zip = '0;
    repeat (3) @(negedge clk);
    check_eq("sb_empty", 128'(sb_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
